seg_scan_scheduler: RTL and testbench

SEG_SCAN_SCHEDULER -- requirements
Module: seg_scan_scheduler

---
 rtl/seg_scan_scheduler.sv | 150 +++++++++++++++
 tb/tb_seg_scan_scheduler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_scheduler.sv
// seg_scan_scheduler: four-digit multiplexed display scanner fed by
// two round-robin requesters through a tear-free double buffer.
module seg_scan_scheduler #(
   parameter int DWELL_CYCLES = 1024,
   parameter int BLANK_LZ     = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_valid,
   input  logic [15:0] a_data,
   output logic        a_ready,
   input  logic        b_valid,
   input  logic [15:0] b_data,
   output logic        b_ready,
   output logic [3:0]  seg_anode,
   output logic [3:0]  bcd_out,
   output logic [15:0] shown_value,
   output logic        last_owner,
   output logic        frame_tick
);

   localparam logic [15:0] CNT_MAX = 16'(DWELL_CYCLES - 1);
   localparam logic        LZ_EN   = (BLANK_LZ != 0);

   logic [1:0]  r_idx;
   logic [15:0] r_cnt;
   logic [15:0] r_active;
   logic [15:0] r_pend;
   logic        r_pfull;
   logic        r_last;
   logic [3:0]  r_anode;
   logic [3:0]  r_bcd;

   logic        w_wrap;
   logic        w_tick;
   logic        w_xfer;
   logic [15:0] w_cnt_nxt;
   logic [1:0]  w_idx_nxt;
   logic [15:0] w_active_nxt;
   logic        w_grant_a;
   logic        w_grant_b;
   logic        w_acc_a;
   logic        w_acc_b;
   logic [3:1]  w_zhi;
   logic        w_blank;
   logic [3:0]  w_nib;
   logic [3:0]  w_anode_nxt;
   logic [3:0]  w_bcd_nxt;

   assign w_wrap    = (r_cnt == CNT_MAX);
   assign w_tick    = w_wrap & (r_idx == 2'd3);
   assign w_cnt_nxt = w_wrap ? 16'd0 : r_cnt + 16'd1;
   assign w_idx_nxt = w_wrap ? r_idx + 2'd1 : r_idx;

   // A pending value only moves to the display at the frame
   // boundary, so a frame never mixes digits of two values.
   assign w_xfer       = w_tick & r_pfull;
   assign w_active_nxt = w_xfer ? r_pend : r_active;

   // Round-robin: on a tie the requester that did not win last.
   assign w_grant_a = a_valid & (~b_valid | r_last);
   assign w_grant_b = b_valid & (~a_valid | ~r_last);

   assign a_ready = ~rst & ~r_pfull & w_grant_a;
   assign b_ready = ~rst & ~r_pfull & w_grant_b;
   assign w_acc_a = a_valid & a_ready;
   assign w_acc_b = b_valid & b_ready;

   // Digit i is a leading zero when it and all digits left of it
   // are zero; computed on the value about to be displayed.
   assign w_zhi[3] = (w_active_nxt[15:12] == 4'h0);
   assign w_zhi[2] = w_zhi[3] & (w_active_nxt[11:8] == 4'h0);
   assign w_zhi[1] = w_zhi[2] & (w_active_nxt[7:4] == 4'h0);

   // Select the next digit nibble and its blanking state.
   always_comb begin
      w_nib   = 4'h0;
      w_blank = 1'b0;
      case (w_idx_nxt)
         2'd0: begin
            w_nib   = w_active_nxt[3:0];
            w_blank = 1'b0;
         end
         2'd1: begin
            w_nib   = w_active_nxt[7:4];
            w_blank = w_zhi[1];
         end
         2'd2: begin
            w_nib   = w_active_nxt[11:8];
            w_blank = w_zhi[2];
         end
         default: begin
            w_nib   = w_active_nxt[15:12];
            w_blank = w_zhi[3];
         end
      endcase
      w_blank = w_blank & LZ_EN;
   end

   assign w_anode_nxt = w_blank ? 4'b1111
                                : ~(4'b0001 << w_idx_nxt);
   assign w_bcd_nxt   = w_blank ? 4'h0 : w_nib;

   // Scan position: dwell counter and digit index.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= 16'd0;
         r_idx <= 2'd0;
      end else begin
         r_cnt <= w_cnt_nxt;
         r_idx <= w_idx_nxt;
      end
   end

   // Pending/active buffer and ownership of the last write.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_active <= 16'h0000;
         r_pend   <= 16'h0000;
         r_pfull  <= 1'b0;
         r_last   <= 1'b1;
      end else if (w_xfer) begin
         r_active <= r_pend;
         r_pfull  <= 1'b0;
      end else if (w_acc_a | w_acc_b) begin
         r_pend  <= w_acc_b ? b_data : a_data;
         r_pfull <= 1'b1;
         r_last  <= w_acc_b;
      end
   end

   // Display drive registered from next-state values so the
   // anode and nibble switch together with the index.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_anode <= 4'b1110;
         r_bcd   <= 4'h0;
      end else begin
         r_anode <= w_anode_nxt;
         r_bcd   <= w_bcd_nxt;
      end
   end

   assign seg_anode   = r_anode;
   assign bcd_out     = r_bcd;
   assign shown_value = r_active;
   assign last_owner  = r_last;
   assign frame_tick  = (r_idx == 2'd3) & (r_cnt == CNT_MAX);

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Bench for seg_scan_scheduler: two instances (BLANK_LZ 0 and 1)
// share stimulus and are checked against a cycle-count model.
module tb_seg_scan_scheduler;

   localparam int DW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        a_valid;
   logic        b_valid;
   logic [15:0] a_data;
   logic [15:0] b_data;

   logic [1:0]        ar;
   logic [1:0]        br;
   logic [1:0][3:0]   an;
   logic [1:0][3:0]   bcd;
   logic [1:0][15:0]  shown;
   logic [1:0]        lo;
   logic [1:0]        ft;

   seg_scan_scheduler #(.DWELL_CYCLES(DW), .BLANK_LZ(0)) u0 (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_data(a_data), .a_ready(ar[0]),
      .b_valid(b_valid), .b_data(b_data), .b_ready(br[0]),
      .seg_anode(an[0]), .bcd_out(bcd[0]),
      .shown_value(shown[0]), .last_owner(lo[0]),
      .frame_tick(ft[0])
   );

   seg_scan_scheduler #(.DWELL_CYCLES(DW), .BLANK_LZ(1)) u1 (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_data(a_data), .a_ready(ar[1]),
      .b_valid(b_valid), .b_data(b_data), .b_ready(br[1]),
      .seg_anode(an[1]), .bcd_out(bcd[1]),
      .shown_value(shown[1]), .last_owner(lo[1]),
      .frame_tick(ft[1])
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name,
                      input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Model: cycles since reset, displayed value, one-deep buffer.
   int          m_t;
   logic [15:0] m_act;
   logic [15:0] m_pend;
   logic        m_pf;
   logic        m_last;
   logic        m_init = 1'b0;
   logic        m_ra;
   logic        m_rb;

   function automatic logic exp_ra();
      if (rst || m_pf || !a_valid) return 1'b0;
      if (b_valid) return m_last;
      return 1'b1;
   endfunction

   function automatic logic exp_rb();
      if (rst || m_pf || !b_valid) return 1'b0;
      if (a_valid) return !m_last;
      return 1'b1;
   endfunction

   function automatic logic [7:0] disp(input logic [15:0] v,
                                       input int t,
                                       input bit blank);
      int         d;
      logic [3:0] nib;
      logic [3:0] ano;
      logic [15:0] hi;
      d   = (t / DW) % 4;
      nib = v[4*d +: 4];
      hi  = v >> (4 * d);
      ano = 4'b1111;
      ano[d] = 1'b0;
      if (blank && d > 0 && hi == 16'h0) return {4'b1111, 4'h0};
      return {ano, nib};
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_t    = 0;
         m_act  = 16'h0;
         m_pend = 16'h0;
         m_pf   = 1'b0;
         m_last = 1'b1;
         m_init = 1'b1;
      end else if (m_init) begin
         m_ra = exp_ra();
         m_rb = exp_rb();
         if ((m_t % (4 * DW)) == 4 * DW - 1 && m_pf) begin
            m_act = m_pend;
            m_pf  = 1'b0;
         end else if (m_ra) begin
            m_pend = a_data;
            m_pf   = 1'b1;
            m_last = 1'b0;
         end else if (m_rb) begin
            m_pend = b_data;
            m_pf   = 1'b1;
            m_last = 1'b1;
         end
         m_t++;
      end
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (m_init) begin
         for (int i = 0; i < 2; i++) begin
            logic [7:0] e;
            e = disp(m_act, m_t, (i == 1));
            chk($sformatf("u%0d.a_ready", i), 16'(ar[i]),
                16'(exp_ra()));
            chk($sformatf("u%0d.b_ready", i), 16'(br[i]),
                16'(exp_rb()));
            chk($sformatf("u%0d.seg_anode", i), 16'(an[i]),
                16'(e[7:4]));
            chk($sformatf("u%0d.bcd_out", i), 16'(bcd[i]),
                16'(e[3:0]));
            chk($sformatf("u%0d.shown_value", i), shown[i], m_act);
            chk($sformatf("u%0d.last_owner", i), 16'(lo[i]),
                16'(m_last));
            chk($sformatf("u%0d.frame_tick", i), 16'(ft[i]),
                16'((m_t % (4 * DW)) == 4 * DW - 1));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      #1;
   endtask

   initial begin
      rst     = 1'b1;
      a_valid = 1'b0;
      b_valid = 1'b0;
      a_data  = 16'h0;
      b_data  = 16'h0;
      tick(2);
      rst = 1'b0;
      #1;
      // idle scan, t=0
      chk("rst_anode", 16'(an[0]), 16'h000e);
      chk("rst_bcd", 16'(bcd[1]), 16'h0000);
      chk("rst_shown", shown[0], 16'h0000);
      chk("rst_owner", 16'(lo[0]), 16'h0001);
      tick(4);
      chk("t4_anode_nb", 16'(an[0]), 16'h000d);
      chk("t4_anode_bl", 16'(an[1]), 16'h000f);
      tick(11);
      chk("t15_tick", 16'(ft[0]), 16'h0001);
      tick(1);
      chk("t16_notick", 16'(ft[0]), 16'h0000);
      chk("t16_anode", 16'(an[0]), 16'h000e);

      // single write 1234 at cycle 2
      do_reset();
      tick(2);
      a_valid = 1'b1;
      a_data  = 16'h1234;
      #1;
      chk("w1234_ready", 16'(ar[0]), 16'h0001);
      tick(1);
      a_valid = 1'b0;
      tick(12);
      chk("w1234_pre", shown[0], 16'h0000);
      chk("w1234_tick", 16'(ft[0]), 16'h0001);
      tick(1);
      chk("w1234_shown", shown[0], 16'h1234);
      chk("w1234_d0", {an[0], 8'h0, bcd[0]}, 16'he004);
      tick(4);
      chk("w1234_d1", {an[0], 8'h0, bcd[0]}, 16'hd003);
      tick(4);
      chk("w1234_d2", {an[0], 8'h0, bcd[0]}, 16'hb002);
      tick(4);
      chk("w1234_d3", {an[1], 8'h0, bcd[1]}, 16'h7001);

      // both requesters valid continuously
      do_reset();
      a_valid = 1'b1;
      b_valid = 1'b1;
      a_data  = 16'h0012;
      b_data  = 16'hfa00;
      #1;
      chk("rr_first_a", {ar[0], br[0]}, 16'h0002);
      tick(1);
      chk("rr_owner_a", 16'(lo[0]), 16'h0000);
      chk("rr_stall", {ar[0], br[0]}, 16'h0000);
      tick(15);
      chk("rr_then_b", {ar[0], br[0]}, 16'h0001);
      chk("rr_shown_a", shown[1], 16'h0012);
      tick(1);
      chk("rr_owner_b", 16'(lo[1]), 16'h0001);
      tick(7);
      chk("rr_blank_d2", {an[1], 8'h0, bcd[1]}, 16'hf000);
      chk("rr_noblank", {an[0], 8'h0, bcd[0]}, 16'hb000);
      tick(8);
      chk("rr_shown_b", shown[0], 16'hfa00);
      chk("rr_a_again", {ar[0], br[0]}, 16'h0002);
      tick(50);
      a_valid = 1'b0;
      b_valid = 1'b0;

      // leading-zero blanking on 0007
      do_reset();
      a_valid = 1'b1;
      a_data  = 16'h0007;
      tick(1);
      a_valid = 1'b0;
      tick(15);
      chk("lz_d0", {an[1], 8'h0, bcd[1]}, 16'he007);
      tick(4);
      chk("lz_d1", {an[1], 8'h0, bcd[1]}, 16'hf000);
      chk("lz_d1_nb", {an[0], 8'h0, bcd[0]}, 16'hd000);
      tick(40);

      // second write stalls until the frame boundary
      do_reset();
      a_valid = 1'b1;
      a_data  = 16'h5555;
      #1;
      chk("st_first", 16'(ar[0]), 16'h0001);
      tick(1);
      a_data = 16'h9999;
      #1;
      chk("st_hold1", 16'(ar[0]), 16'h0000);
      tick(7);
      chk("st_hold8", 16'(ar[1]), 16'h0000);
      tick(7);
      chk("st_hold15", 16'(ar[0]), 16'h0000);
      tick(1);
      chk("st_accept", 16'(ar[0]), 16'h0001);
      chk("st_show5", shown[0], 16'h5555);
      tick(1);
      a_valid = 1'b0;
      tick(15);
      chk("st_show9", shown[0], 16'h9999);

      // reset pulse mid-frame with a pending value
      do_reset();
      a_valid = 1'b1;
      a_data  = 16'h4321;
      tick(1);
      a_valid = 1'b0;
      tick(5);
      rst     = 1'b1;
      a_valid = 1'b1;
      a_data  = 16'h1111;
      #1;
      chk("rp_ready_rst", {ar[0], br[0]}, 16'h0000);
      tick(1);
      chk("rp_ready_rst2", 16'(ar[1]), 16'h0000);
      rst     = 1'b0;
      a_valid = 1'b0;
      #1;
      chk("rp_shown", shown[0], 16'h0000);
      chk("rp_anode", 16'(an[0]), 16'h000e);
      tick(15);
      chk("rp_tick", 16'(ft[0]), 16'h0001);
      tick(1);
      chk("rp_dropped", shown[1], 16'h0000);
      tick(8);

      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
